// File: rtl/lod_seq_scan.sv
// Sequential leading-one detector: scans one nibble per cycle, MS nibble first.
// Optional Mitchell mantissa output is enabled by defining LOD_SEQ_MANT_EN.
module lod_seq_scan #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned POS_W  = $clog2(DATA_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [POS_W-1:0]  out_pos,
  output logic              out_zero,
  output logic [DATA_W-2:0] out_mant
);

  localparam int unsigned NIB = DATA_W / 4;
  localparam int unsigned K_W = (NIB > 1) ? $clog2(NIB) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nx;
  logic [DATA_W-1:0] opnd;
  logic [K_W-1:0]    k;
  logic [3:0]        nib;
  logic              nib_hit;
  logic [1:0]        nib_pos;
  logic [POS_W-1:0]  hit_pos;

  // Single nibble LOD slice on the currently selected nibble.
  assign nib     = 4'(opnd >> {k, 2'b00});
  assign nib_hit = |nib;
  assign nib_pos = (nib[3] | nib[2]) ? {1'b1, nib[3]} : {1'b0, nib[1]};
  assign hit_pos = POS_W'({k, nib_pos});

  // Acceptance is suppressed while reset is held, even once the FSM sits in IDLE.
  assign in_ready = (state == S_IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (in_valid)           state_nx = S_SCAN;
      S_SCAN:  if (nib_hit || k == '0) state_nx = S_DONE;
      S_DONE:  if (out_ready)          state_nx = S_IDLE;
      default:                         state_nx = S_IDLE;
    endcase
  end

  // Operand latch, nibble index and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      opnd      <= '0;
      k         <= '0;
      out_valid <= 1'b0;
      out_pos   <= '0;
      out_zero  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            opnd <= in_data;
            k    <= K_W'(NIB - 1);
          end
        end
        S_SCAN: begin
          if (nib_hit) begin
            out_pos   <= hit_pos;
            out_zero  <= 1'b0;
            out_valid <= 1'b1;
          end else if (k == '0) begin
            out_pos   <= '0;
            out_zero  <= 1'b1;
            out_valid <= 1'b1;
          end else begin
            k <= k - 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

`ifdef LOD_SEQ_MANT_EN
  logic [POS_W-1:0]  mant_sh;
  logic [DATA_W-1:0] mant_full;
  logic [DATA_W-2:0] mant_q;

  // Left-align the bits below the leading one so they form the fraction.
  assign mant_sh   = POS_W'(DATA_W - 1) - hit_pos;
  assign mant_full = opnd << mant_sh;

  always_ff @(posedge clk) begin
    if (rst) begin
      mant_q <= '0;
    end else if (state == S_SCAN) begin
      if (nib_hit)         mant_q <= mant_full[DATA_W-2:0];
      else if (k == '0)    mant_q <= '0;
    end
  end

  assign out_mant = mant_q;
`else
  assign out_mant = '0;
`endif

endmodule

// File: tb/tb_lod_seq_scan.sv
// Self-checking bench for lod_seq_scan: vector table, hand sequences and random
// operands against a bit-scanning reference model (16-bit and 4-bit instances).
module tb_lod_seq_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [15:0] in_data;
  logic [3:0]  out_pos;
  logic [14:0] out_mant;

  logic        in_valid4, in_ready4, out_valid4, out_ready4, out_zero4;
  logic [3:0]  in_data4;
  logic [1:0]  out_pos4;
  logic [2:0]  out_mant4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lod_seq_scan #(.DATA_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pos(out_pos), .out_zero(out_zero),
    .out_mant(out_mant)
  );

  lod_seq_scan #(.DATA_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
    .out_valid(out_valid4), .out_ready(out_ready4), .out_pos(out_pos4), .out_zero(out_zero4),
    .out_mant(out_mant4)
  );

  typedef struct {
    logic [15:0] data;
    int          lat;
    int          pos;
    bit          zero;
    logic [14:0] mant;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Reference: highest set bit by plain scan; fraction = (x - 2^pos) scaled to w-1 bits.
  function automatic void model(input longint unsigned x, input int w, output int pos,
                                output bit zero, output int lat, output longint unsigned mant);
    pos  = 0;
    zero = 1'b1;
    for (int b = 0; b < w; b++) if (x[b]) begin pos = b; zero = 1'b0; end
    lat  = zero ? (w / 4) : (w / 4 - pos / 4);
    mant = zero ? 64'd0 : ((x - (64'd1 << pos)) << (w - 1 - pos));
`ifndef LOD_SEQ_MANT_EN
    mant = 64'd0;
`endif
  endfunction

  task automatic op16(input string tag, input logic [15:0] d, input int e_lat, input int e_pos,
                      input bit e_zero, input logic [63:0] e_mant);
    int j;
    @(negedge clk);
    in_data = d; in_valid = 1'b1; out_ready = 1'b1;
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 16'($urandom);
    j = 0;
    while (out_valid !== 1'b1 && j < 40) begin @(negedge clk); j++; end
    chk({tag, "_latency"}, 64'(j), 64'(e_lat));
    chk({tag, "_pos"}, 64'(out_pos), 64'(e_pos));
    chk({tag, "_zero"}, 64'(out_zero), 64'(e_zero));
    chk({tag, "_mant"}, 64'(out_mant), e_mant);
    @(negedge clk);
    chk({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
  endtask

  task automatic op4(input string tag, input logic [3:0] d);
    int j, e_pos, e_lat;
    bit e_zero;
    longint unsigned e_mant;
    model(64'(d), 4, e_pos, e_zero, e_lat, e_mant);
    @(negedge clk);
    in_data4 = d; in_valid4 = 1'b1; out_ready4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid4 = 1'b0;
    j = 0;
    while (out_valid4 !== 1'b1 && j < 40) begin @(negedge clk); j++; end
    chk({tag, "_latency"}, 64'(j), 64'(e_lat));
    chk({tag, "_pos"}, 64'(out_pos4), 64'(e_pos));
    chk({tag, "_zero"}, 64'(out_zero4), 64'(e_zero));
    chk({tag, "_mant"}, 64'(out_mant4), e_mant);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[6];
    int j, m_pos, m_lat, w;
    bit m_zero;
    longint unsigned m_mant;
    int unsigned mask;
    logic [15:0] x;
    logic [63:0] em;

    tbl[0] = '{16'h8000, 1, 15, 1'b0, 15'h0000};
    tbl[1] = '{16'h0B30, 2, 11, 1'b0, 15'h3300};
    tbl[2] = '{16'h0001, 4,  0, 1'b0, 15'h0000};
    tbl[3] = '{16'h0000, 4,  0, 1'b1, 15'h0000};
    tbl[4] = '{16'h1234, 1, 12, 1'b0, 15'h11A0};
    tbl[5] = '{16'h00C0, 3,  7, 1'b0, 15'h4000};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in_valid4 = 1'b0; in_data4 = '0; out_ready4 = 1'b1;

    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_pos", 64'(out_pos), 64'd0);
    chk("rst_zero", 64'(out_zero), 64'd0);
    chk("rst_mant", 64'(out_mant), 64'd0);
    chk("rst_in_ready4", 64'(in_ready4), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_release_in_ready", 64'(in_ready), 64'd1);

    for (int i = 0; i < 6; i++) begin
`ifdef LOD_SEQ_MANT_EN
      em = 64'(tbl[i].mant);
`else
      em = 64'd0;
`endif
      op16($sformatf("vec%0d", i), tbl[i].data, tbl[i].lat, tbl[i].pos, tbl[i].zero, em);
    end

    // Backpressure with a competing operand offered throughout.
    @(negedge clk);
    in_data = 16'h0B30; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_data = 16'h1234;
    j = 0;
    while (out_valid !== 1'b1 && j < 40) begin @(negedge clk); j++; end
    chk("bp_latency", 64'(j), 64'd2);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid_hold", 64'(out_valid), 64'd1);
      chk("bp_pos_hold", 64'(out_pos), 64'd11);
      chk("bp_zero_hold", 64'(out_zero), 64'd0);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_valid_drop", 64'(out_valid), 64'd0);
    chk("bp_idle_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    j = 0;
    while (out_valid !== 1'b1 && j < 40) begin @(negedge clk); j++; end
    chk("bp_next_latency", 64'(j), 64'd1);
    chk("bp_next_pos", 64'(out_pos), 64'd12);
    @(negedge clk);

    // Reset in the middle of a scan aborts the operation.
    @(negedge clk);
    in_data = 16'h0002; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_pos", 64'(out_pos), 64'd0);
    chk("mid_rst_zero", 64'(out_zero), 64'd0);
    chk("mid_rst_mant", 64'(out_mant), 64'd0);
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("mid_rst_no_result", 64'(out_valid), 64'd0);
    end
    op16("post_rst", 16'h0400, 2, 10, 1'b0, 64'd0);

    // Random operands with a random number of live low bits.
    for (int i = 0; i < 40; i++) begin
      w    = int'($urandom_range(0, 16));
      mask = (32'd1 << w) - 32'd1;
      x    = 16'($urandom & mask);
      model(64'(x), 16, m_pos, m_zero, m_lat, m_mant);
      op16($sformatf("rand%0d_%04h", i, x), x, m_lat, m_pos, m_zero, m_mant);
    end

    op4("w4_5", 4'h5);
    op4("w4_0", 4'h0);
    for (int v = 0; v < 16; v++) op4($sformatf("w4_all_%0h", v), 4'(v));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lod_seq_scan.md
# lod_seq_scan

Multi-cycle leading-one detector for wide operands in the log-domain datapath. It scans the operand one 4-bit nibble per cycle, most significant nibble first, using a single nibble LOD slice. It returns the leading-one position, a zero flag and, optionally, the Mitchell mantissa. It sits in front of the log converter and replaces a wide combinational LOD tree where area matters more than latency.

## Interface
- `DATA_W`, 16, operand width; multiple of 4, range 4..64.
- `POS_W`, `$clog2(DATA_W)`, width of the position output; derived, do not override.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operand offered.
- `in_ready`  out  1  block can accept an operand; high only in IDLE.
- `in_data`  in  DATA_W  operand.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `out_pos`  out  POS_W  bit index of the leading one.
- `out_zero`  out  1  operand was all zeros.
- `out_mant`  out  DATA_W-1  bits below the leading one, left-aligned (see Configuration).

## Operation
- FSM states: IDLE, SCAN, DONE. NIB = DATA_W/4.
- IDLE:
  - `in_ready`=1.
  - On `in_valid & in_ready`, latch `in_data`, set nibble index k=NIB-1, go to SCAN.
- SCAN: each cycle, examine nibble k of the latched operand.
  - Nibble LOD: the slice is valid if any bit is set. Its 2-bit position is {hi-pair valid, bit3} when bit3 or bit2 is set, else {0, bit1}.
  - Hit: register `out_pos` = 4k + nibble position and `out_zero`=0, then go to DONE.
  - Miss with k>0: decrement k and stay in SCAN.
  - Miss with k==0: register `out_pos`=0 and `out_zero`=1, then go to DONE.
- DONE:
  - `out_valid`=1; all outputs hold stable until `out_valid & out_ready`.
  - Then go to IDLE; `out_valid` drops on the next cycle.
- No pipelining: only one operand is in flight. `in_valid` is ignored outside IDLE and nothing is latched.
- Arithmetic: `out_pos` is unsigned in 0..DATA_W-1. k is a `$clog2(NIB)`-bit counter (minimum 1 bit) and never wraps below 0.

## Timing
- Reset (any state, takes effect at the next edge):
  - state=IDLE.
  - `out_valid`=0, `out_pos`=0, `out_zero`=0, `out_mant`=0.
  - `in_ready`=0 while `rst` is high; `in_ready`=1 in the first cycle after `rst` deasserts.
- Reset mid-SCAN or mid-DONE aborts the operation. No result is emitted.
- Latency: let accept be edge E0 and let the leading one lie in nibble kL. `out_valid` rises after edge Ej, with j = NIB-kL, range 1..NIB. An all-zero operand gives j=NIB.
- Best-case throughput is one operand per j+2 cycles: result handshake at E(j+1), IDLE, next accept at E(j+2).
- `out_ready` high before DONE has no effect. `out_ready` held high completes the handshake in the first DONE cycle.

## Configuration
- Macro `LOD_SEQ_MANT_EN`.
- Defined:
  - On the DONE transition, register `out_mant` = (operand << (DATA_W-1-out_pos))[DATA_W-2:0]. This is the Mitchell fractional part, valid together with `out_valid`.
  - An all-zero operand gives `out_mant`=0.
- Undefined:
  - `out_mant` is tied to 0, with no shifter and no mantissa register.
  - The port remains present.
  - All other behaviour and timing are identical.

## Test plan
- `in_data`=0x8000, `out_ready`=1 -> `out_valid` after E1, `out_pos`=15, `out_zero`=0, `out_mant`=0x0000.
- `in_data`=0x0B30 -> `out_valid` after E2, `out_pos`=11, `out_mant`=0x3300 (MANT_EN) / 0x0000 (no MANT_EN).
- `in_data`=0x0001 -> after E4, `out_pos`=0, `out_zero`=0, `out_mant`=0. `in_data`=0x0000 -> after E4, `out_pos`=0, `out_zero`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE while driving `in_valid`=1 with 0x1234.
  - Outputs stay stable and `in_ready`=0.
  - After the handshake, IDLE accepts 0x1234 and yields `out_pos`=12.
- Reset: assert `rst` for 1 cycle during SCAN of 0x0002.
  - No `out_valid` is produced; all outputs are 0 and `in_ready`=1 on the next cycle.
  - A subsequent 0x0400 yields `out_pos`=10 after E2.
- DATA_W=4 instance: 0x5 -> `out_pos`=2 after E1; 0x0 -> `out_zero`=1 after E1.
